// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan capture: segment bit positions,
// square glyphs, the hex glyph table and anode classification helpers.
package sseg_pkg;

    localparam int SEG_G  = 0;
    localparam int SEG_F  = 1;
    localparam int SEG_E  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_C  = 4;
    localparam int SEG_B  = 5;
    localparam int SEG_A  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SQ_TOP   = 8'h9C;
    localparam logic [7:0] SQ_BOT   = 8'hE2;
    localparam logic [3:0] AN_BLANK = 4'hF;

    // Active-low {a..g} patterns for 0-9, A, b, C, d, E, F.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef enum logic [1:0] {
        AN_NONE   = 2'd0,
        AN_SINGLE = 2'd1,
        AN_MULTI  = 2'd2
    } an_class_e;

    function automatic an_class_e an_classify(input logic [3:0] an);
        logic [3:0] low;
        low = ~an;
        if (an == AN_BLANK) begin
            an_classify = AN_NONE;
        end else if ((low & (low - 4'd1)) == 4'd0) begin
            an_classify = AN_SINGLE;
        end else begin
            an_classify = AN_MULTI;
        end
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        case (an)
            4'b1110: an_index = 2'd0;
            4'b1101: an_index = 2'd1;
            4'b1011: an_index = 2'd2;
            4'b0111: an_index = 2'd3;
            default: an_index = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational reverse lookup of an active-low {a..g} pattern into a hex nibble.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);

    // Table search; glyphs are unique so at most one entry matches.
    always_comb begin
        valid  = 1'b0;
        nibble = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (seg == GLYPH_TABLE[k]) begin
                valid  = 1'b1;
                nibble = 4'(k);
            end else begin
                valid  = valid;
                nibble = nibble;
            end
        end
    end

endmodule

// File: rtl/sseg_scan_capture.sv
// Rebuilds the per-digit display frame from a multiplexed an/sseg bus once a
// pattern has been stable for STABLE_CYCLES consecutive samples.
module sseg_scan_capture
    import sseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int RUN_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  sseg,
    output logic [31:0] digit_seg,
    output logic [15:0] hex,
    output logic [3:0]  hex_valid,
    output logic [3:0]  dp,
    output logic [2:0]  square_pos,
    output logic        square_valid,
    output logic        frame_tick,
    output logic        bus_err
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(STABLE_CYCLES - 1);
    localparam bit               SINGLE_STAGE = (STABLE_CYCLES == 1);

    logic [11:0]      s1_r;
    logic [RUN_W-1:0] run_cnt_r;
    logic [3:0]       seen_r;

    logic [11:0]      sample_s;
    logic [11:0]      cand_s;
    logic [RUN_W-1:0] run_next_s;
    logic             accept_s;
    logic             dec_valid_s;
    logic [3:0]       dec_nib_s;
    an_class_e        class_s;
    logic [1:0]       idx_s;
    logic [3:0]       seen_next_s;

    assign sample_s = {an, sseg};
    // With a one-sample window the accepted pattern is the one arriving now,
    // otherwise it is already sitting in s1.
    assign cand_s      = SINGLE_STAGE ? sample_s : s1_r;
    assign class_s     = an_classify(cand_s[11:8]);
    assign idx_s       = an_index(cand_s[11:8]);
    assign seen_next_s = seen_r | (4'b0001 << idx_s);

    sseg_hex_decode u_dec (
        .seg    (cand_s[6:0]),
        .valid  (dec_valid_s),
        .nibble (dec_nib_s)
    );

    // Run-length tracking; accept fires only on the edge the run reaches the limit.
    always_comb begin
        run_next_s = run_cnt_r;
        accept_s   = 1'b0;
        if (sample_s != s1_r) begin
            run_next_s = RUN_W'(1);
            accept_s   = SINGLE_STAGE;
        end else if (run_cnt_r < RUN_MAX) begin
            run_next_s = run_cnt_r + RUN_W'(1);
            accept_s   = (run_cnt_r == RUN_PRE);
        end else begin
            run_next_s = run_cnt_r;
            accept_s   = 1'b0;
        end
    end

    // Sampling state and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r         <= {4'hF, 8'hFF};
            run_cnt_r    <= '0;
            seen_r       <= 4'h0;
            digit_seg    <= 32'hFFFF_FFFF;
            hex          <= 16'h0000;
            hex_valid    <= 4'h0;
            dp           <= 4'h0;
            square_pos   <= 3'd0;
            square_valid <= 1'b0;
            frame_tick   <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            s1_r       <= sample_s;
            run_cnt_r  <= run_next_s;
            frame_tick <= 1'b0;
            bus_err    <= 1'b0;
            if (accept_s) begin
                case (class_s)
                    AN_SINGLE: begin
                        digit_seg[{idx_s, 3'b000} +: 8] <= cand_s[7:0];
                        dp[idx_s]                       <= ~cand_s[SEG_DP];
                        hex[{idx_s, 2'b00} +: 4]        <= dec_nib_s;
                        hex_valid[idx_s]                <= dec_valid_s;
                        if (cand_s[7:0] == SQ_TOP) begin
                            square_pos   <= {1'b1, idx_s};
                            square_valid <= 1'b1;
                        end else if (cand_s[7:0] == SQ_BOT) begin
                            square_pos   <= {1'b0, idx_s};
                            square_valid <= 1'b1;
                        end else begin
                            square_valid <= 1'b0;
                        end
                        if (seen_next_s == 4'hF) begin
                            frame_tick <= 1'b1;
                            seen_r     <= 4'h0;
                        end else begin
                            seen_r <= seen_next_s;
                        end
                    end
                    AN_MULTI: bus_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Scoreboard bench: stimulus queues the expected frame for each observable
// output event, a forked monitor pops and compares when the DUT presents one.
module tb_sseg_scan_capture;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  an = 4'hF;
    logic [7:0]  sseg = 8'hFF;
    logic [31:0] digit_seg;
    logic [15:0] hex;
    logic [3:0]  hex_valid;
    logic [3:0]  dp;
    logic [2:0]  square_pos;
    logic        square_valid;
    logic        frame_tick;
    logic        bus_err;

    sseg_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk          (clk),
        .reset        (reset),
        .an           (an),
        .sseg         (sseg),
        .digit_seg    (digit_seg),
        .hex          (hex),
        .hex_valid    (hex_valid),
        .dp           (dp),
        .square_pos   (square_pos),
        .square_valid (square_valid),
        .frame_tick   (frame_tick),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] ds;
        logic [15:0] hx;
        logic [3:0]  hv;
        logic [3:0]  dpv;
        logic [2:0]  sp;
        logic        sv;
        logic        ft;
        logic        be;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t q[$];
    exp_t st;
    int checks = 0;
    int errors = 0;

    function automatic exp_t reset_state();
        exp_t r;
        r.ds = 32'hFFFF_FFFF; r.hx = 16'h0; r.hv = 4'h0; r.dpv = 4'h0;
        r.sp = 3'd0; r.sv = 1'b0; r.ft = 1'b0; r.be = 1'b0; r.cyc = 0; r.tag = "reset";
        return r;
    endfunction

    function automatic exp_t snap();
        exp_t r;
        r.ds = digit_seg; r.hx = hex; r.hv = hex_valid; r.dpv = dp;
        r.sp = square_pos; r.sv = square_valid; r.ft = frame_tick; r.be = bus_err;
        r.cyc = cyc; r.tag = "dut";
        return r;
    endfunction

    function automatic bit same_persist(input exp_t x, input exp_t y);
        return (x.ds === y.ds) && (x.hx === y.hx) && (x.hv === y.hv) &&
               (x.dpv === y.dpv) && (x.sp === y.sp) && (x.sv === y.sv);
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("ds=%h hex=%h hv=%b dp=%b sp=%0d sv=%b ft=%b be=%b cyc=%0d",
                         x.ds, x.hx, x.hv, x.dpv, x.sp, x.sv, x.ft, x.be, x.cyc);
    endfunction

    // Quiescent check: persistent outputs match the model and no pulse is active.
    task automatic check_state(input string tag);
        exp_t c;
        c = snap();
        checks++;
        if (!same_persist(c, st) || c.ft !== 1'b0 || c.be !== 1'b0) begin
            errors++;
            $display("FAIL hold_%s: got %s, expected %s", tag, fmt(c), fmt(st));
        end
    endtask

    // Drive one bus pattern for n cycles with hand-computed expected effect.
    task automatic apply(input logic [3:0] a, input logic [7:0] s, input int n,
                         input bit upd, input int d, input logic [3:0] nib,
                         input logic hv, input logic sv, input logic [2:0] sp,
                         input logic ft, input logic be, input string tag);
        exp_t nx;
        nx = st;
        if (upd) begin
            nx.ds[8*d +: 8] = s;
            nx.dpv[d]       = ~s[7];
            nx.hx[4*d +: 4] = nib;
            nx.hv[d]        = hv;
            nx.sv           = sv;
            nx.sp           = sp;
        end
        nx.ft  = ft;
        nx.be  = be;
        nx.cyc = cyc + STABLE;
        nx.tag = tag;
        if (!same_persist(nx, st) || ft || be) q.push_back(nx);
        st = nx;
        st.ft = 1'b0;
        st.be = 1'b0;
        an   = a;
        sseg = s;
        repeat (n) @(negedge clk);
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        exp_t nx;
        nx = reset_state();
        nx.cyc = cyc + 1;
        nx.tag = tag;
        q.push_back(nx);
        st = reset_state();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_state(tag);
    endtask

    initial begin
        st = reset_state();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_state("reset");

        fork
            begin
                exp_t prev, cur, e;
                prev = reset_state();
                forever begin
                    @(negedge clk);
                    cur = snap();
                    if (!same_persist(cur, prev) || cur.ft === 1'b1 || cur.be === 1'b1) begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_event: got %s, expected no event", fmt(cur));
                        end else begin
                            e = q.pop_front();
                            if (!same_persist(cur, e) || cur.ft !== e.ft ||
                                cur.be !== e.be || cur.cyc != e.cyc) begin
                                errors++;
                                $display("FAIL event_%s: got %s, expected %s", e.tag, fmt(cur), fmt(e));
                            end
                        end
                    end
                    prev = cur;
                end
            end
        join_none

        // 1: top square on digit 0
        apply(4'b1110, 8'h9C, 6, 1'b1, 0, 4'h0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, "t1_sq_top0");
        // 2: short run, then blank
        apply(4'b1101, 8'hCF, 3, 1'b0, 0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "t2_short");
        apply(4'b1111, 8'hFF, 5, 1'b0, 0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "t2_blank");
        // 3: digits 1,2,3,4 across positions 0..3
        apply(4'b1110, 8'hCF, 6, 1'b1, 0, 4'h1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, "t3_d0");
        apply(4'b1101, 8'h92, 6, 1'b1, 1, 4'h2, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, "t3_d1");
        apply(4'b1011, 8'h86, 6, 1'b1, 2, 4'h3, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, "t3_d2");
        apply(4'b0111, 8'hCC, 6, 1'b1, 3, 4'h4, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, "t3_d3");
        // 4: two anodes low held
        apply(4'b1100, 8'h00, 10, 1'b0, 0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, "t4_bus_err");
        // 5: clockwise square
        apply(4'b1110, 8'hE2, 5, 1'b1, 0, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "t5_b0");
        apply(4'b1101, 8'hE2, 5, 1'b1, 1, 4'h0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, "t5_b1");
        apply(4'b1011, 8'hE2, 5, 1'b1, 2, 4'h0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, "t5_b2");
        apply(4'b0111, 8'hE2, 5, 1'b1, 3, 4'h0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, "t5_b3");
        apply(4'b0111, 8'h9C, 5, 1'b1, 3, 4'h0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, "t5_t3");
        apply(4'b1011, 8'h9C, 5, 1'b1, 2, 4'h0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, "t5_t2");
        apply(4'b1101, 8'h9C, 5, 1'b1, 1, 4'h0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, "t5_t1");
        apply(4'b1110, 8'h9C, 5, 1'b1, 0, 4'h0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, "t5_t0");
        // 6: partial frame, reset, then the other half
        apply(4'b1110, 8'hCF, 5, 1'b1, 0, 4'h1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, "t6_d0");
        apply(4'b1101, 8'h92, 5, 1'b1, 1, 4'h2, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, "t6_d1");
        do_reset("t6_reset");
        apply(4'b1011, 8'h86, 5, 1'b1, 2, 4'h3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, "t6_d2");
        apply(4'b0111, 8'hCC, 5, 1'b1, 3, 4'h4, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, "t6_d3");

        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d unmatched, expected 0 (first %s)", q.size(), q[0].tag);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
